bg_scan_ctrl: RTL
=================

BG_SCAN_CTRL -- requirements
Module: bg_scan_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, image columns.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, image rows.
REQ-003 SHALL have parameters SCREEN_WIDTH, default 800, and SCREEN_HEIGHT, default 600, giving the clip limits.
REQ-004 SHALL have parameter ROM_LATENCY, default 1 (legal 1..4), ROM read latency in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: pulse that begins a frame scan.
REQ-008 SHALL have ports anchor_x and anchor_y, input, 10 bits each: screen position of image pixel (0,0), captured at start.
REQ-009 SHALL have port ready_in, input, 1 bit: downstream accepts a pixel; low means stall.
REQ-010 SHALL have ports rom_addr, output, 19 bits, and rom_en, output, 1 bit: the image ROM read request.
REQ-011 SHALL have port pix_valid, output, 1 bit, aligned with the ROM data for the same address.
REQ-012 SHALL have ports pix_x and pix_y, output, 10 bits each: screen coordinates of the current pixel.
REQ-013 SHALL have ports busy, output, 1 bit, and done, output, 1 bit; done is a single-cycle pulse.

Function
REQ-014 SHALL implement the states IDLE, SCAN, DRAIN and DONE.
REQ-015 In IDLE, start SHALL capture the anchors, clear the column and row counters and address, and move to SCAN on the next cycle.
REQ-016 In SCAN with ready_in=1, the block SHALL assert rom_en, issue rom_addr = row*IMAGE_WIDTH+col, and advance col.
REQ-017 When col wraps from IMAGE_WIDTH-1 to 0, row SHALL increment; the address SHALL be formed incrementally (+1 per pixel), with no multiplier.
REQ-018 Issuing the last pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) SHALL move the FSM to DRAIN.
REQ-019 DRAIN SHALL last ROM_LATENCY advancing cycles and then move to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-020 pix_valid, pix_x and pix_y SHALL lag the matching rom_en/rom_addr by exactly ROM_LATENCY advancing cycles, through a shift pipeline.
REQ-021 pix_x SHALL equal anchor_x+col and pix_y SHALL equal anchor_y+row, computed at 11-bit width with no wrap.
REQ-022 A pixel with anchor_x+col >= SCREEN_WIDTH or anchor_y+row >= SCREEN_HEIGHT SHALL keep its address slot but SHALL have pix_valid=0 (clipped).
REQ-023 With ready_in=0, the counters, rom_addr and the pipeline SHALL hold, rom_en SHALL be 0, and the pix_* outputs SHALL hold their values.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 busy SHALL be 1 in SCAN, DRAIN and DONE, and 0 in IDLE.

Reset
REQ-026 While rst_n=0, the block SHALL enter IDLE, clear the counters and pipeline, and drive rom_addr=0, rom_en=0, pix_valid=0, pix_x=0, pix_y=0, busy=0 and done=0, all asynchronously.
REQ-027 Reset asserted mid-scan SHALL abort the frame, with no done pulse.
REQ-028 After reset is released, the block SHALL do nothing until a new start.

Configuration
REQ-029 With macro BG_SCAN_CONTINUOUS_EN defined, DONE SHALL return directly to SCAN with the counters cleared and the anchors re-captured, giving back-to-back frames; done still pulses each frame.
REQ-030 With macro BG_SCAN_CONTINUOUS_EN defined, deasserting start while in DONE SHALL return the block to IDLE instead.
REQ-031 Without BG_SCAN_CONTINUOUS_EN, every frame SHALL require its own start.

Structure
REQ-032 Package bg_pkg SHALL hold the state enum, the screen and image size constants, and the address width constant (19).
REQ-033 The ROM_LATENCY delay line SHALL be a sub-module named bg_pix_pipe (enable-gated shift register for valid, x and y).

Verification
REQ-034 Reset, start, anchor (0,0), ready_in=1 -> 307200 rom_en cycles; pix_valid goes high exactly 1 cycle after the first rom_en; done pulses once; last rom_addr=307199.
REQ-035 Anchor (200,150) -> first pixel at (200,150); columns with pix_x >= 800 and rows with pix_y >= 600 are flagged pix_valid=0; the address count is still 307200.
REQ-036 ready_in toggled 0/1 every 3 cycles -> the pixel sequence is identical to the unstalled run, and rom_en=0 in every cycle with ready_in=0.
REQ-037 rst_n pulled low at pixel 1000 -> all outputs go to 0 at once with no done pulse; a following start restarts at rom_addr=0.
REQ-038 ROM_LATENCY=3 -> pix_valid lags rom_en by 3 cycles and DRAIN lasts 3 cycles.
REQ-039 With BG_SCAN_CONTINUOUS_EN defined -> 2 frames back to back, with no idle cycle between the last addr 307199 and the next addr 0.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared types and size constants for the background scan controller.
package bg_pkg;

    localparam int ADDR_W    = 19;
    localparam int COORD_W   = 10;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int SCR_W_DEF = 800;
    localparam int SCR_H_DEF = 600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/bg_pix_pipe.sv
// Enable-gated delay line that carries pixel valid/x/y alongside the ROM read latency.
module bg_pix_pipe
    import bg_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = COORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         valid_in,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic         valid_out,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out
);

    logic [DEPTH-1:0] v_sr;
    logic [W-1:0]     x_sr [DEPTH];
    logic [W-1:0]     y_sr [DEPTH];

    // Stages only move on advancing cycles so a stall freezes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                x_sr[i] <= '0;
                y_sr[i] <= '0;
            end
        end else if (en) begin
            v_sr[0] <= valid_in;
            x_sr[0] <= x_in;
            y_sr[0] <= y_in;
            for (int i = 1; i < DEPTH; i++) begin
                v_sr[i] <= v_sr[i-1];
                x_sr[i] <= x_sr[i-1];
                y_sr[i] <= y_sr[i-1];
            end
        end
    end

    assign valid_out = v_sr[DEPTH-1];
    assign x_out     = x_sr[DEPTH-1];
    assign y_out     = y_sr[DEPTH-1];

endmodule

// File: rtl/bg_scan_ctrl.sv
// Raster scan of a background image ROM with screen clipping and stall support.
// Define BG_SCAN_CONTINUOUS_EN to chain frames back to back while start stays high.
module bg_scan_ctrl
    import bg_pkg::*;
#(
    parameter int IMAGE_WIDTH   = IMG_W_DEF,
    parameter int IMAGE_HEIGHT  = IMG_H_DEF,
    parameter int SCREEN_WIDTH  = SCR_W_DEF,
    parameter int SCREEN_HEIGHT = SCR_H_DEF,
    parameter int ROM_LATENCY   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] anchor_x,
    input  logic [COORD_W-1:0] anchor_y,
    input  logic               ready_in,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_en,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               busy,
    output logic               done
);

    scan_state_t        state, state_nxt;
    logic [COORD_W-1:0] col, row, ax_q, ay_q;
    logic [2:0]         drain_cnt;
    logic               capture, advance, last_pix, drain_end;
    logic [COORD_W:0]   sum_x, sum_y;
    logic               in_screen;

    assign last_pix  = (col == COORD_W'(IMAGE_WIDTH - 1)) && (row == COORD_W'(IMAGE_HEIGHT - 1));
    assign drain_end = (drain_cnt == 3'(ROM_LATENCY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (ready_in) begin
                    rom_en  = 1'b1;
                    advance = 1'b1;
                    if (last_pix) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (ready_in) begin
                    advance = 1'b1;
                    if (drain_end) state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
`ifdef BG_SCAN_CONTINUOUS_EN
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The last pixel leaves the counters parked so rom_addr keeps showing the final address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            rom_addr  <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            drain_cnt <= '0;
        end else if (capture) begin
            col       <= '0;
            row       <= '0;
            rom_addr  <= '0;
            ax_q      <= anchor_x;
            ay_q      <= anchor_y;
            drain_cnt <= '0;
        end else if (advance) begin
            if (state == SCAN) begin
                if (!last_pix) begin
                    rom_addr <= rom_addr + 1'b1;
                    if (col == COORD_W'(IMAGE_WIDTH - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end else begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    assign sum_x     = {1'b0, ax_q} + {1'b0, col};
    assign sum_y     = {1'b0, ay_q} + {1'b0, row};
    assign in_screen = (sum_x < (COORD_W+1)'(SCREEN_WIDTH)) && (sum_y < (COORD_W+1)'(SCREEN_HEIGHT));

    bg_pix_pipe #(
        .DEPTH (ROM_LATENCY),
        .W     (COORD_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (advance),
        .valid_in  ((state == SCAN) && in_screen),
        .x_in      (sum_x[COORD_W-1:0]),
        .y_in      (sum_y[COORD_W-1:0]),
        .valid_out (pix_valid),
        .x_out     (pix_x),
        .y_out     (pix_y)
    );

endmodule
